t2mi_timestamp_parser: RTL and testbench
========================================

// Module: t2mi_timestamp_parser
// PURPOSE
//  Parametrised successor timestamp parser for T2-MI timestamp packets (type 0x20 by default).
//  Sits after the T2-MI packet splitter and feeds the PPS/time-of-day generator.
//  Adds the following over the single-shot extractor:
//   - stream-id filtering
//   - strict length checking
//   - a coded error report and a drop counter
//   - a FIFO output with valid/ready handshake
// PARAMETERS
//  TS_PACKET_TYPE  8'h20  packet_type value accepted as a timestamp packet
//  TS_BYTES        12     payload bytes per packet (layout below; must be >=12)
//  FIFO_DEPTH      4      output record FIFO depth (power of 2, >=2)
//  SID_W           8      stream-id width
// PORTS
//  clk               in   1      system clock
//  rst_n             in   1      synchronous active-low reset
//  packet_valid      in   1      packet_data byte valid
//  packet_type       in   8      T2-MI packet type, sampled on packet_start
//  packet_stream_id  in   SID_W  stream id, sampled on packet_start
//  packet_data       in   8      payload byte
//  packet_start      in   1      packet header strobe
//  packet_end        in   1      last-cycle strobe
//  cfg_filter_en     in   1      1: accept only packet_stream_id==cfg_stream_id
//  cfg_stream_id     in   SID_W  accepted stream id
//  ts_valid          out  1      FIFO head record valid
//  ts_ready          in   1      consumer accepts head (pop when ts_valid&ts_ready)
//  ts_seconds        out  40     seconds since 2000-01-01
//  ts_subsec         out  32     subseconds, units of 2^-32 s
//  ts_utco           out  13     UTC offset, seconds
//  ts_bw             out  4      bandwidth code
//  ts_sid            out  SID_W  stream id of record
//  fifo_level        out  clog2(FIFO_DEPTH)+1  records held
//  err_pulse         out  1      one-cycle error strobe
//  err_code          out  3      code; valid with err_pulse, else 0
//  drop_count        out  16     saturating count of discarded packets
// BEHAVIOUR
//  Reset (rst_n low at clk edge):
//   - all outputs are 0; FIFO empty; capture idle.
//   - a capture in progress is discarded without an error.
//  Capture states: IDLE, CAPTURE, DISCARD.
//   - IDLE: packet_start & type match & (!cfg_filter_en | sid match) -> CAPTURE, byte count=0.
//   - IDLE: packet_start otherwise -> DISCARD.
//   - A data byte is a packet_valid cycle after the packet_start cycle; start-cycle data is ignored.
//   - packet_valid & packet_end in the same cycle: the byte counts, then the packet is evaluated.
//   - CAPTURE|DISCARD & packet_start: the current packet is closed and the new one begins.
//     An unfinished CAPTURE reports err 1 (short).
//   - packet_end -> IDLE.
//  Byte layout:
//   - b0[7:4] rfu (must be 0); b0[3:0] bw
//   - utco = {b1[4:0], b2}; b1[7:5] ignored
//   - seconds = b3..b7, MSB first
//   - subsec = b8..b11, MSB first
//   - bytes 12..TS_BYTES-1 are ignored
//  Evaluation at packet_end (cycle N) in CAPTURE. Error codes and priority:
//   - 1: count < TS_BYTES (short)
//   - 2: count > TS_BYTES (long; excess bytes are counted, not stored)
//   - 3: rfu != 0
//   - 5: non-monotonic (macro only)
//   - 4: FIFO full and no pop in cycle N (overflow)
//  Evaluation result:
//   - Error: err_pulse/err_code in N+1, record discarded, drop_count+1 (saturates at 16'hFFFF).
//   - No error: record written at end of N; with FIFO empty, ts_valid=1 in N+1 (first-word-fall-through).
//  FIFO:
//   - Full with a simultaneous pop in N: the push is accepted.
//   - Outputs hold the head record until popped.
//   - ts_* equal the head record whenever ts_valid=1.
//  Only one error is reported per packet. DISCARD packets are dropped silently and not counted.
// CONFIGURATION
//  TS_MONO_CHECK_EN defined:
//   - keeps the last pushed {seconds,subsec}
//   - a new record must be strictly greater, else err 5 and drop
//   - the first record after reset always passes
//  TS_MONO_CHECK_EN undefined: no comparison, no storage; code 5 is never produced.
// TESTING
//  1 type 0x20, 12 bytes 00 00 12 00 2A 3B 4C 5D 80 00 00 00, ts_ready=1
//    -> ts_valid in N+1; seconds=40'h002A3B4C5D; subsec=32'h80000000; utco=18; bw=0.
//  2 11-byte packet, then 13-byte packet -> err_code 1, then 2; drop_count=2; ts_valid stays 0.
//  3 b0=0x13 -> err_code 3; a following type 0x10 packet -> no record, no error.
//  4 cfg_filter_en=1, cfg_stream_id=3; valid packets with sid 2 then 3
//    -> exactly one record, ts_sid=3.
//  5 ts_ready=0, 5 valid packets (depth 4) -> fifo_level=4, err_code 4 once, drop_count=1;
//    the packet_end coinciding with a pop is accepted.
//  6 TS_MONO_CHECK_EN: seconds 100 then 99 -> err_code 5, then 101 accepted.
//    rst_n low mid-capture -> no error, outputs 0.

Source files
------------

// File: rtl/t2mi_timestamp_parser.sv
// T2-MI timestamp packet parser: filters by type/stream id, checks length and rfu bits, and queues
// good records in a first-word-fall-through FIFO. Define TS_MONO_CHECK_EN to reject non-increasing timestamps.
module t2mi_timestamp_parser #(
    parameter logic [7:0] TS_PACKET_TYPE = 8'h20,
    parameter int         TS_BYTES       = 12,
    parameter int         FIFO_DEPTH     = 4,
    parameter int         SID_W          = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        packet_valid,
    input  logic [7:0]                  packet_type,
    input  logic [SID_W-1:0]            packet_stream_id,
    input  logic [7:0]                  packet_data,
    input  logic                        packet_start,
    input  logic                        packet_end,
    input  logic                        cfg_filter_en,
    input  logic [SID_W-1:0]            cfg_stream_id,
    output logic                        ts_valid,
    input  logic                        ts_ready,
    output logic [39:0]                 ts_seconds,
    output logic [31:0]                 ts_subsec,
    output logic [12:0]                 ts_utco,
    output logic [3:0]                  ts_bw,
    output logic [SID_W-1:0]            ts_sid,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        err_pulse,
    output logic [2:0]                  err_code,
    output logic [15:0]                 drop_count
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LW    = AW + 1;
    localparam int CW    = $clog2(TS_BYTES + 2);
    localparam int REC_W = 89 + SID_W;
    localparam logic [CW-1:0] LEN_C  = CW'(TS_BYTES);
    localparam logic [LW-1:0] FULL_C = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DISCARD} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [SID_W-1:0]   sid_q, sid_d;
    logic [7:0]         pkt_bytes_q [12];
    logic [7:0]         pkt_bytes_d [12];
    logic [REC_W-1:0]   mem_q [FIFO_DEPTH];
    logic [REC_W-1:0]   mem_d [FIFO_DEPTH];
    logic [AW-1:0]      wr_q, wr_d, rd_q, rd_d;
    logic [LW-1:0]      lvl_q, lvl_d;
    logic [REC_W-1:0]   head_q, head_d;
    logic               valid_q, valid_d;
    logic               err_pulse_q, err_pulse_d;
    logic [2:0]         err_code_q, err_code_d;
    logic [15:0]        drop_q, drop_d;
    logic               accept_s, eval_s, start_err_s, push_s, pop_s, full_s, rfu_s, mono_bad_s;
    logic [2:0]         code_s;
    logic [REC_W-1:0]   rec_s;

    // Capture state machine next-state and byte collection (start-cycle data is never stored).
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sid_d       = sid_q;
        pkt_bytes_d = pkt_bytes_q;
        eval_s      = 1'b0;
        start_err_s = 1'b0;
        accept_s    = (packet_type == TS_PACKET_TYPE) &&
                      (!cfg_filter_en || (packet_stream_id == cfg_stream_id));
        if (packet_start) begin
            start_err_s = (state_q == S_CAPTURE) || (accept_s && packet_end);
            sid_d       = packet_stream_id;
            cnt_d       = '0;
            if (packet_end)    state_d = S_IDLE;
            else if (accept_s) state_d = S_CAPTURE;
            else               state_d = S_DISCARD;
        end else if (state_q == S_CAPTURE) begin
            if (packet_valid) begin
                for (int i = 0; i < 12; i++) begin
                    if (cnt_q == CW'(i)) pkt_bytes_d[i] = packet_data;
                    else                 pkt_bytes_d[i] = pkt_bytes_q[i];
                end
                // Saturate one past the nominal length: enough to flag a long packet.
                if (cnt_q <= LEN_C) cnt_d = cnt_q + CW'(1);
                else                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q;
            end
            if (packet_end) begin
                state_d = S_IDLE;
                eval_s  = 1'b1;
            end else begin
                state_d = state_q;
            end
        end else if ((state_q == S_DISCARD) && packet_end) begin
            state_d = S_IDLE;
        end else begin
            state_d = state_q;
        end
    end

    assign rec_s = {pkt_bytes_d[3], pkt_bytes_d[4], pkt_bytes_d[5], pkt_bytes_d[6], pkt_bytes_d[7],
                    pkt_bytes_d[8], pkt_bytes_d[9], pkt_bytes_d[10], pkt_bytes_d[11],
                    pkt_bytes_d[1][4:0], pkt_bytes_d[2], pkt_bytes_d[0][3:0], sid_q};
    assign rfu_s  = (pkt_bytes_d[0][7:4] != 4'd0);
    assign pop_s  = valid_q & ts_ready;
    assign full_s = (lvl_q == FULL_C);

`ifdef TS_MONO_CHECK_EN
    logic [71:0] last_q, last_d;
    logic        have_last_q, have_last_d;

    assign mono_bad_s = have_last_q && (rec_s[REC_W-1 -: 72] <= last_q);

    // Remember the most recently pushed timestamp.
    always_comb begin
        if (push_s) begin
            last_d      = rec_s[REC_W-1 -: 72];
            have_last_d = 1'b1;
        end else begin
            last_d      = last_q;
            have_last_d = have_last_q;
        end
    end

    // Last-timestamp register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q      <= 72'd0;
            have_last_q <= 1'b0;
        end else begin
            last_q      <= last_d;
            have_last_q <= have_last_d;
        end
    end
`else
    assign mono_bad_s = 1'b0;
`endif

    // Packet verdict in priority order; a push into a full FIFO is fine when the head leaves this cycle.
    always_comb begin
        code_s = 3'd0;
        if (start_err_s) begin
            code_s = 3'd1;
        end else if (eval_s) begin
            if (cnt_d < LEN_C)           code_s = 3'd1;
            else if (cnt_d > LEN_C)      code_s = 3'd2;
            else if (rfu_s)              code_s = 3'd3;
            else if (mono_bad_s)         code_s = 3'd5;
            else if (full_s && !pop_s)   code_s = 3'd4;
            else                         code_s = 3'd0;
        end else begin
            code_s = 3'd0;
        end
        push_s = eval_s && (code_s == 3'd0);
    end

    // Record FIFO, error report and drop counter; head_d pre-computes the next head for FWFT output.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push_s) begin
            mem_d[wr_q] = rec_s;
            wr_d        = wr_q + AW'(1);
        end else begin
            wr_d = wr_q;
        end
        if (pop_s) rd_d = rd_q + AW'(1);
        else       rd_d = rd_q;
        case ({push_s, pop_s})
            2'b10:   lvl_d = lvl_q + LW'(1);
            2'b01:   lvl_d = lvl_q - LW'(1);
            default: lvl_d = lvl_q;
        endcase
        valid_d = (lvl_d != '0);
        if (valid_d) head_d = mem_d[rd_d];
        else         head_d = '0;
        err_pulse_d = (code_s != 3'd0);
        err_code_d  = code_s;
        if (err_pulse_d && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
        else                                     drop_d = drop_q;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sid_q       <= '0;
            for (int i = 0; i < 12; i++) pkt_bytes_q[i] <= 8'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            lvl_q       <= '0;
            head_q      <= '0;
            valid_q     <= 1'b0;
            err_pulse_q <= 1'b0;
            err_code_q  <= 3'd0;
            drop_q      <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sid_q       <= sid_d;
            pkt_bytes_q <= pkt_bytes_d;
            mem_q       <= mem_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            lvl_q       <= lvl_d;
            head_q      <= head_d;
            valid_q     <= valid_d;
            err_pulse_q <= err_pulse_d;
            err_code_q  <= err_code_d;
            drop_q      <= drop_d;
        end
    end

    assign ts_valid   = valid_q;
    assign ts_seconds = head_q[SID_W+88:SID_W+49];
    assign ts_subsec  = head_q[SID_W+48:SID_W+17];
    assign ts_utco    = head_q[SID_W+16:SID_W+4];
    assign ts_bw      = head_q[SID_W+3:SID_W];
    assign ts_sid     = head_q[SID_W-1:0];
    assign fifo_level = lvl_q;
    assign err_pulse  = err_pulse_q;
    assign err_code   = err_code_q;
    assign drop_count = drop_q;
endmodule

// File: tb/tb_t2mi_timestamp_parser.sv
// Randomized bench for t2mi_timestamp_parser: every cycle the DUT outputs are compared with a
// packet-level reference model (byte queues, arithmetic field decode, record queue).
module tb_t2mi_timestamp_parser;
    logic        clk = 1'b0;
    logic        rst_n, packet_valid, packet_start, packet_end, cfg_filter_en, ts_ready;
    logic [7:0]  packet_type, packet_stream_id, packet_data, cfg_stream_id;
    logic        ts_valid, err_pulse;
    logic [39:0] ts_seconds;
    logic [31:0] ts_subsec;
    logic [12:0] ts_utco;
    logic [3:0]  ts_bw;
    logic [7:0]  ts_sid;
    logic [2:0]  fifo_level, err_code;
    logic [15:0] drop_count;

    always #5 clk = ~clk;

    t2mi_timestamp_parser dut (
        .clk(clk), .rst_n(rst_n), .packet_valid(packet_valid), .packet_type(packet_type),
        .packet_stream_id(packet_stream_id), .packet_data(packet_data), .packet_start(packet_start),
        .packet_end(packet_end), .cfg_filter_en(cfg_filter_en), .cfg_stream_id(cfg_stream_id),
        .ts_valid(ts_valid), .ts_ready(ts_ready), .ts_seconds(ts_seconds), .ts_subsec(ts_subsec),
        .ts_utco(ts_utco), .ts_bw(ts_bw), .ts_sid(ts_sid), .fifo_level(fifo_level),
        .err_pulse(err_pulse), .err_code(err_code), .drop_count(drop_count)
    );

    typedef struct {
        logic [39:0] sec;
        logic [31:0] sub;
        logic [12:0] utco;
        logic [3:0]  bw;
        logic [7:0]  sid;
    } rec_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    rec_t        mq[$];
    logic [7:0]  m_bytes[$];
    int          m_mode;          // 0 idle, 1 capturing, 2 discarding
    logic [7:0]  m_sid;
    logic        exp_err;
    logic [2:0]  exp_code;
    int          exp_drop;
    bit          m_have_last;
    longint      m_lsec, m_lsub;
    int          ready_mode;      // 0 never, 1 always, 2 random, 3 only on packet_end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_step();
        bit     pop, acc, push;
        logic [2:0] code;
        rec_t   r;
        longint s, u;
        if (!rst_n) begin
            mq.delete(); m_bytes.delete();
            m_mode = 0; exp_err = 1'b0; exp_code = 3'd0; exp_drop = 0; m_have_last = 1'b0;
            return;
        end
        pop  = (mq.size() != 0) && ts_ready;
        code = 3'd0;
        push = 1'b0;
        if (packet_start) begin
            if (m_mode == 1) code = 3'd1;
            acc = (packet_type == 8'h20) && (!cfg_filter_en || packet_stream_id == cfg_stream_id);
            m_mode = acc ? 1 : 2;
            m_bytes.delete();
            m_sid = packet_stream_id;
            if (packet_end) begin
                m_mode = 0;
                if (acc && code == 3'd0) code = 3'd1;
            end
        end else if (m_mode == 1) begin
            if (packet_valid) m_bytes.push_back(packet_data);
            if (packet_end) begin
                m_mode = 0;
                if (m_bytes.size() < 12)      code = 3'd1;
                else if (m_bytes.size() > 12) code = 3'd2;
                else if (m_bytes[0] >= 16)    code = 3'd3;
                else begin
                    s = 0; u = 0;
                    for (int k = 3; k <= 7; k++)  s = s * 256 + longint'(m_bytes[k]);
                    for (int k = 8; k <= 11; k++) u = u * 256 + longint'(m_bytes[k]);
                    r.sec  = s[39:0];
                    r.sub  = u[31:0];
                    r.utco = 13'((int'(m_bytes[1]) % 32) * 256 + int'(m_bytes[2]));
                    r.bw   = 4'(int'(m_bytes[0]) % 16);
                    r.sid  = m_sid;
`ifdef TS_MONO_CHECK_EN
                    if (m_have_last && !(s > m_lsec || (s == m_lsec && u > m_lsub))) code = 3'd5;
`endif
                    if (code == 3'd0) begin
                        if (mq.size() == 4 && !pop) code = 3'd4;
                        else begin
                            push = 1'b1; m_have_last = 1'b1; m_lsec = s; m_lsub = u;
                        end
                    end
                end
            end
        end else if (m_mode == 2 && packet_end) begin
            m_mode = 0;
        end
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back(r);
        if (code != 3'd0 && exp_drop < 65535) exp_drop++;
        exp_err  = (code != 3'd0);
        exp_code = code;
    endtask

    task automatic tick();
        rec_t h;
        case (ready_mode)
            0:       ts_ready = 1'b0;
            1:       ts_ready = 1'b1;
            2:       ts_ready = 1'($urandom_range(0, 1));
            default: ts_ready = packet_end;
        endcase
        @(posedge clk);
        model_step();
        #1;
        h.sec = '0; h.sub = '0; h.utco = '0; h.bw = '0; h.sid = '0;
        if (mq.size() != 0) h = mq[0];
        check_eq("ts_valid",   ts_valid,   (mq.size() != 0));
        check_eq("ts_seconds", ts_seconds, h.sec);
        check_eq("ts_subsec",  ts_subsec,  h.sub);
        check_eq("ts_utco",    ts_utco,    h.utco);
        check_eq("ts_bw",      ts_bw,      h.bw);
        check_eq("ts_sid",     ts_sid,     h.sid);
        check_eq("fifo_level", fifo_level, mq.size());
        check_eq("err_pulse",  err_pulse,  exp_err);
        check_eq("err_code",   err_code,   exp_code);
        check_eq("drop_count", drop_count, exp_drop);
    endtask

    task automatic idle(input int n);
        packet_valid = 1'b0; packet_start = 1'b0; packet_end = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
    endtask

    // Drives one packet; returns in the cycle after its last byte (or after the start if len==0).
    task automatic send_pkt(input logic [7:0] typ, input logic [7:0] sid, input int len,
                            input logic [7:0] b0, input logic [39:0] sec, input logic [31:0] sub,
                            input logic [12:0] utco, input bit gaps, input bit no_end);
        logic [7:0] d [16];
        for (int i = 0; i < 16; i++) d[i] = 8'($urandom);
        d[0] = b0;
        d[1] = {d[1][7:5], utco[12:8]};
        d[2] = utco[7:0];
        for (int k = 0; k < 5; k++) d[3+k] = sec[8*(4-k) +: 8];
        for (int k = 0; k < 4; k++) d[8+k] = sub[8*(3-k) +: 8];
        packet_start = 1'b1; packet_type = typ; packet_stream_id = sid;
        packet_valid = 1'($urandom_range(0, 1)); packet_data = 8'($urandom); packet_end = 1'b0;
        tick();
        packet_start = 1'b0; packet_type = 8'($urandom); packet_stream_id = 8'($urandom);
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                packet_valid = 1'b0;
                tick();
            end
            packet_valid = 1'b1;
            packet_data  = d[i];
            packet_end   = (i == len - 1) && !no_end;
            tick();
        end
        packet_valid = 1'b0; packet_end = 1'b0;
    endtask

    initial begin
        logic [39:0] rsec;
        rst_n = 1'b0; packet_valid = 1'b0; packet_start = 1'b0; packet_end = 1'b0;
        packet_type = 8'h00; packet_stream_id = 8'h00; packet_data = 8'h00;
        cfg_filter_en = 1'b0; cfg_stream_id = 8'h00; ts_ready = 1'b0; ready_mode = 1;
        do_reset();
        check_eq("reset_valid", ts_valid, 1'b0);
        check_eq("reset_drop",  drop_count, 16'd0);
        idle(2);

        // Nominal packet, consumer always ready.
        send_pkt(8'h20, 8'h00, 12, 8'h00, 40'h002A3B4C5D, 32'h80000000, 13'd18, 1'b0, 1'b0);
        check_eq("t1_valid", ts_valid,   1'b1);
        check_eq("t1_sec",   ts_seconds, 40'h002A3B4C5D);
        check_eq("t1_sub",   ts_subsec,  32'h80000000);
        check_eq("t1_utco",  ts_utco,    13'd18);
        check_eq("t1_bw",    ts_bw,      4'd0);
        idle(3);

        // Short then long packet.
        send_pkt(8'h20, 8'h00, 11, 8'h01, 40'd5, 32'd6, 13'd7, 1'b0, 1'b0);
        check_eq("t2_code_short", err_code, 3'd1);
        idle(2);
        send_pkt(8'h20, 8'h00, 13, 8'h01, 40'd5, 32'd6, 13'd7, 1'b0, 1'b0);
        check_eq("t2_code_long", err_code, 3'd2);
        check_eq("t2_drop", drop_count, 16'd2);
        idle(2);

        // rfu bits set, then a foreign packet type.
        send_pkt(8'h20, 8'h00, 12, 8'h13, 40'd9, 32'd9, 13'd9, 1'b0, 1'b0);
        check_eq("t3_code_rfu", err_code, 3'd3);
        send_pkt(8'h10, 8'h00, 12, 8'h00, 40'd9, 32'd9, 13'd9, 1'b0, 1'b0);
        check_eq("t3_foreign_err", err_pulse, 1'b0);
        idle(2);

        // Stream-id filter.
        do_reset();
        ready_mode = 0; cfg_filter_en = 1'b1; cfg_stream_id = 8'h03;
        send_pkt(8'h20, 8'h02, 12, 8'h02, 40'd20, 32'd1, 13'd3, 1'b0, 1'b0);
        send_pkt(8'h20, 8'h03, 12, 8'h02, 40'd21, 32'd1, 13'd3, 1'b0, 1'b0);
        idle(1);
        check_eq("t4_level", fifo_level, 3'd1);
        check_eq("t4_sid",   ts_sid,     8'h03);
        cfg_filter_en = 1'b0;
        do_reset();

        // Overflow with a stalled consumer, then a push coinciding with a pop.
        for (int i = 0; i < 5; i++)
            send_pkt(8'h20, 8'h01, 12, 8'h00, 40'(30 + i), 32'd0, 13'd0, 1'b0, 1'b0);
        check_eq("t5_code_ovf", err_code, 3'd4);
        check_eq("t5_level",    fifo_level, 3'd4);
        check_eq("t5_drop",     drop_count, 16'd1);
        ready_mode = 3;
        send_pkt(8'h20, 8'h01, 12, 8'h00, 40'd40, 32'd0, 13'd0, 1'b0, 1'b0);
        check_eq("t5_push_on_pop", err_pulse, 1'b0);
        check_eq("t5_level_kept",  fifo_level, 3'd4);
        ready_mode = 1;
        idle(6);

        // Timestamp ordering: 100, 99, 101.
        do_reset();
        send_pkt(8'h20, 8'h00, 12, 8'h00, 40'd100, 32'd0, 13'd0, 1'b0, 1'b0);
        send_pkt(8'h20, 8'h00, 12, 8'h00, 40'd99,  32'd0, 13'd0, 1'b0, 1'b0);
`ifdef TS_MONO_CHECK_EN
        check_eq("t6_code_mono", err_code, 3'd5);
`else
        check_eq("t6_no_mono", err_pulse, 1'b0);
`endif
        send_pkt(8'h20, 8'h00, 12, 8'h00, 40'd101, 32'd0, 13'd0, 1'b0, 1'b0);
        check_eq("t6_accept", err_pulse, 1'b0);
        idle(2);

        // Reset in the middle of a capture.
        send_pkt(8'h20, 8'h00, 6, 8'h00, 40'd7, 32'd7, 13'd7, 1'b0, 1'b1);
        do_reset();
        check_eq("t7_err",  err_pulse,  1'b0);
        check_eq("t7_drop", drop_count, 16'd0);
        idle(2);

        // Randomized traffic.
        ready_mode = 2;
        rsec = 40'd1000;
        for (int p = 0; p < 80; p++) begin
            int   r, len;
            logic [7:0] b0;
            if (p % 20 == 0) begin
                cfg_filter_en = 1'($urandom_range(0, 1));
                cfg_stream_id = 8'($urandom_range(0, 3));
            end
            r   = $urandom_range(0, 9);
            len = (r < 6) ? 12 : $urandom_range(10, 14);
            b0  = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) b0 = b0 | 8'h40;
            rsec = rsec + 40'($urandom_range(0, 3)) - 40'($urandom_range(0, 1));
            send_pkt(($urandom_range(0, 7) == 0) ? 8'h10 : 8'h20, 8'($urandom_range(0, 3)), len, b0,
                     rsec, 32'($urandom), 13'($urandom), 1'b1, (p != 79) && ($urandom_range(0, 9) == 0));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        ready_mode = 1;
        idle(8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
